cam_linereader: RTL and testbench

- Consumes the 50MHz-domain pixel stream from cambus_photon (vid_pixel/vid_pixsync/vid_hblank/vid_vblank).
- Assembles active pixels into complete lines in a two-bank ping-pong line buffer.
- Tracks line number within the frame and presents each finished line to a downstream consumer with a valid/ack handshake.
- Drops whole lines when both banks are occupied, and counts every drop.

---
 rtl/cam_pkg.sv | 30 +++
 rtl/cam_linereader_ram.sv | 28 ++
 rtl/cam_linereader.sv | 232 +++++++++++++++++++++++
 tb/tb_cam_linereader.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared types and constants for the camera line reader: pixel width,
// per-line metadata record and the writer FSM state encoding.
package cam_pkg;

  localparam int unsigned PIXEL_W       = 14;
  localparam int unsigned CAM_MAX_WIDTH = 640;
  localparam int unsigned CAM_ADDR_W    = $clog2(CAM_MAX_WIDTH);
  localparam int unsigned CAM_LINE_W    = 10;

  // Field widths track the default top-level geometry; raise them here
  // before instantiating a wider line buffer or a longer line counter.
  typedef struct packed {
    logic [CAM_LINE_W-1:0] num;
    logic [CAM_ADDR_W:0]   len;
    logic                  first;
    logic                  trunc;
  } line_meta_t;

  typedef enum logic [1:0] {
    VBLANK,
    WAIT_LINE,
    ACTIVE,
    DROP
  } writer_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == '1) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/cam_linereader_ram.sv
// Two-bank pixel line store: simple dual-port RAM addressed as {bank, pixel},
// synchronous write and registered read so it maps onto block RAM.
module cam_linereader_ram
  import cam_pkg::*;
#(
  parameter int unsigned ADDR_W = CAM_ADDR_W
) (
  input  logic               clk_i,
  input  logic               we_i,
  input  logic [ADDR_W:0]    waddr_i,
  input  logic [PIXEL_W-1:0] wdata_i,
  input  logic [ADDR_W:0]    raddr_i,
  output logic [PIXEL_W-1:0] rdata_o
);

  // Bank select is the address MSB, so each bank spans a full power-of-two window.
  localparam int unsigned DEPTH = 2 ** (ADDR_W + 1);

  logic [PIXEL_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/cam_linereader.sv
// Assembles strobed camera pixels into lines in a ping-pong buffer and hands
// finished lines to a consumer via valid/ack; lines with no free bank are dropped.
module cam_linereader
  import cam_pkg::*;
#(
  parameter int unsigned MAX_WIDTH = CAM_MAX_WIDTH,
  parameter int unsigned ADDR_W    = $clog2(MAX_WIDTH),
  parameter int unsigned LINE_W    = CAM_LINE_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PIXEL_W-1:0] vid_pixel,
  input  logic               vid_pixsync,
  input  logic               vid_hblank,
  input  logic               vid_vblank,
  output logic               line_valid,
  output logic [LINE_W-1:0]  line_num,
  output logic [ADDR_W:0]    line_len,
  output logic               line_first,
  output logic               line_trunc,
  input  logic               line_ack,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [PIXEL_W-1:0] rd_data,
  output logic               frame_start,
  output logic [15:0]        drop_count
);

  localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W + 1)'(MAX_WIDTH);

  writer_state_t      state_q;
  logic [ADDR_W:0]    wp_q;
  logic               trunc_q;
  logic               first_q;
  logic               wbank_q;
  logic [LINE_W-1:0]  line_cnt_q;
  logic               frame_start_q;
  logic [15:0]        drop_q;

  logic [1:0]         full_q, full_d;
  logic               head_q, head_d;
  line_meta_t         meta_q [2];
  line_meta_t         pres_q, pres_d;
  logic               line_valid_q, line_valid_d;
  logic               rd_ok_q;

  logic               active_px;
  logic               line_end;
  logic               bank_free;
  logic               free_bank;
  logic               commit;
  logic               pop;
  logic [1:0]         remaining;
  line_meta_t         commit_meta;

  logic               wr_en;
  logic               wr_bank;
  logic [ADDR_W-1:0]  wr_ptr;
  logic [PIXEL_W-1:0] ram_rdata;

  assign active_px = vid_pixsync & ~vid_hblank & ~vid_vblank;
  assign line_end  = vid_pixsync & (vid_hblank | vid_vblank);
  assign bank_free = ~&full_q;
  assign free_bank = full_q[0];
  assign commit    = (state_q == ACTIVE) && line_end;
  assign pop       = line_valid_q & line_ack;

  always_comb begin
    commit_meta.num   = CAM_LINE_W'(line_cnt_q);
    commit_meta.len   = (CAM_ADDR_W + 1)'(wp_q);
    commit_meta.first = first_q;
    commit_meta.trunc = trunc_q;
  end

  // The pixel that opens a line is written to address 0 of the newly claimed bank.
  always_comb begin
    wr_en   = 1'b0;
    wr_bank = wbank_q;
    wr_ptr  = wp_q[ADDR_W-1:0];
    case (state_q)
      VBLANK, WAIT_LINE: begin
        if (active_px && bank_free) begin
          wr_en   = 1'b1;
          wr_bank = free_bank;
          wr_ptr  = '0;
        end
      end
      ACTIVE: begin
        if (active_px && (wp_q < MAX_LEN)) begin
          wr_en = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= VBLANK;
      wp_q          <= '0;
      trunc_q       <= 1'b0;
      first_q       <= 1'b0;
      wbank_q       <= 1'b0;
      line_cnt_q    <= '0;
      frame_start_q <= 1'b0;
      drop_q        <= '0;
    end else begin
      frame_start_q <= 1'b0;
      unique case (state_q)
        VBLANK: begin
          if (active_px) begin
            frame_start_q <= 1'b1;
            line_cnt_q    <= '0;
            first_q       <= 1'b1;
            state_q       <= bank_free ? ACTIVE : DROP;
            wbank_q       <= free_bank;
            wp_q          <= (ADDR_W + 1)'(1);
            trunc_q       <= 1'b0;
          end
        end
        WAIT_LINE: begin
          if (vid_pixsync && vid_vblank) begin
            state_q <= VBLANK;
          end else if (active_px) begin
            line_cnt_q <= line_cnt_q + 1'b1;
            first_q    <= 1'b0;
            state_q    <= bank_free ? ACTIVE : DROP;
            wbank_q    <= free_bank;
            wp_q       <= (ADDR_W + 1)'(1);
            trunc_q    <= 1'b0;
          end
        end
        ACTIVE: begin
          if (line_end) begin
            state_q <= vid_vblank ? VBLANK : WAIT_LINE;
          end else if (active_px) begin
            if (wp_q < MAX_LEN) begin
              wp_q <= wp_q + 1'b1;
            end else begin
              trunc_q <= 1'b1;
            end
          end
        end
        DROP: begin
          if (line_end) begin
            drop_q  <= sat_inc16(drop_q);
            state_q <= vid_vblank ? VBLANK : WAIT_LINE;
          end
        end
      endcase
    end
  end

  // Full banks form a two-deep FIFO; head_q names the oldest one.
  always_comb begin
    full_d    = full_q;
    remaining = full_q;
    if (pop) begin
      full_d[head_q]    = 1'b0;
      remaining[head_q] = 1'b0;
    end
    if (commit) begin
      full_d[wbank_q] = 1'b1;
    end
    head_d = head_q;
    if (commit && (remaining == '0)) begin
      head_d = wbank_q;
    end else if (pop) begin
      head_d = ~head_q;
    end
  end

  // An idle reader picks up a commit in the same edge; after an ack the next
  // full bank is only presented from the registered state, giving the one-cycle gap.
  always_comb begin
    line_valid_d = line_valid_q;
    pres_d       = pres_q;
    if (line_valid_q) begin
      if (pop) begin
        line_valid_d = 1'b0;
      end
    end else if (full_q != '0) begin
      line_valid_d = 1'b1;
      pres_d       = meta_q[head_q];
    end else if (commit) begin
      line_valid_d = 1'b1;
      pres_d       = commit_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q       <= '0;
      head_q       <= 1'b0;
      meta_q[0]    <= '0;
      meta_q[1]    <= '0;
      pres_q       <= '0;
      line_valid_q <= 1'b0;
      rd_ok_q      <= 1'b0;
    end else begin
      full_q       <= full_d;
      head_q       <= head_d;
      pres_q       <= pres_d;
      line_valid_q <= line_valid_d;
      rd_ok_q      <= 1'b1;
      if (commit) begin
        meta_q[wbank_q] <= commit_meta;
      end
    end
  end

  cam_linereader_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (wr_en),
    .waddr_i ({wr_bank, wr_ptr}),
    .wdata_i (vid_pixel),
    .raddr_i ({head_q, rd_addr}),
    .rdata_o (ram_rdata)
  );

  // The RAM read register has no reset; masking keeps rd_data at zero out of reset.
  assign rd_data     = rd_ok_q ? ram_rdata : '0;
  assign line_valid  = line_valid_q;
  assign line_num    = LINE_W'(pres_q.num);
  assign line_len    = (ADDR_W + 1)'(pres_q.len);
  assign line_first  = pres_q.first;
  assign line_trunc  = pres_q.trunc;
  assign frame_start = frame_start_q;
  assign drop_count  = drop_q;

endmodule

// File: tb/tb_cam_linereader.sv
// Scoreboard bench for cam_linereader: expected lines are queued as they are
// sent and checked (metadata and pixel contents) when the DUT presents them.
module tb_cam_linereader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [13:0] vid_pixel = '0;
  logic        vid_pixsync = 1'b0;
  logic        vid_hblank = 1'b0;
  logic        vid_vblank = 1'b0;
  logic        line_valid;
  logic [9:0]  line_num;
  logic [10:0] line_len;
  logic        line_first;
  logic        line_trunc;
  logic        line_ack = 1'b0;
  logic [9:0]  rd_addr = '0;
  logic [13:0] rd_data;
  logic        frame_start;
  logic [15:0] drop_count;

  always #10 clk = ~clk;

  cam_linereader dut (
    .clk         (clk),
    .rst         (rst),
    .vid_pixel   (vid_pixel),
    .vid_pixsync (vid_pixsync),
    .vid_hblank  (vid_hblank),
    .vid_vblank  (vid_vblank),
    .line_valid  (line_valid),
    .line_num    (line_num),
    .line_len    (line_len),
    .line_first  (line_first),
    .line_trunc  (line_trunc),
    .line_ack    (line_ack),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .frame_start (frame_start),
    .drop_count  (drop_count)
  );

  typedef struct {
    int num;
    int len;
    bit first;
    bit trunc;
    int seed;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  bit   auto_ack = 1'b0;
  int   fs_count = 0;
  int   fs_exp = 0;
  int   next_num = 0;
  bit   in_vblank = 1'b1;
  int   seed_n = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [13:0] pix(input int seed, input int i);
    return 14'(seed * 1024 + i + 1);
  endfunction

  task automatic strobe(input logic [13:0] p, input logic hb, input logic vb);
    @(posedge clk); #1;
    vid_pixel   = p;
    vid_hblank  = hb;
    vid_vblank  = vb;
    vid_pixsync = 1'b1;
    @(posedge clk); #1;
    vid_pixsync = 1'b0;
  endtask

  task automatic send_vblank();
    strobe(14'h0, 1'b0, 1'b1);
    in_vblank = 1'b1;
  endtask

  task automatic send_line(input int n, input bit kept, input bit end_vb, input bit chk_lv);
    exp_t e;
    bit   newf;
    newf    = in_vblank;
    e.num   = newf ? 0 : next_num;
    e.len   = (n > 640) ? 640 : n;
    e.trunc = (n > 640);
    e.first = newf;
    e.seed  = seed_n++;
    next_num = e.num + 1;
    if (kept) sb.push_back(e);
    if (newf) fs_exp++;
    for (int i = 0; i < n; i++) begin
      strobe(pix(e.seed, i), 1'b0, 1'b0);
      if (i == 0 && newf) chk("frame_start_pulse", frame_start, 1);
    end
    strobe(14'h3fff, !end_vb, end_vb);
    in_vblank = end_vb;
    if (chk_lv) begin
      chk("lv_latency", line_valid, 1);
      chk("lv_num", line_num, e.num);
    end
  endtask

  task automatic consume_line(input bit do_ack);
    exp_t e;
    int   addrs[$];
    chk("sb_has_entry", 32'(sb.size() != 0), 1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk("num", line_num, e.num);
    chk("len", line_len, e.len);
    chk("first", line_first, e.first);
    chk("trunc", line_trunc, e.trunc);
    if (e.len <= 16) begin
      for (int a = 0; a < e.len; a++) addrs.push_back(a);
    end else begin
      addrs.push_back(0);
      addrs.push_back(1);
      addrs.push_back(e.len / 2);
      addrs.push_back(e.len - 1);
    end
    foreach (addrs[k]) begin
      rd_addr = 10'(addrs[k]);
      @(negedge clk);
      chk("rd_data", rd_data, pix(e.seed, addrs[k]));
    end
    chk("hold_valid", line_valid, 1);
    chk("hold_num", line_num, e.num);
    if (do_ack) begin
      line_ack = 1'b1;
      @(negedge clk);
      line_ack = 1'b0;
      chk("valid_drop", line_valid, 0);
    end
  endtask

  task automatic wait_drain();
    int c;
    c = 0;
    while ((sb.size() != 0 || line_valid === 1'b1) && c < 4000) begin
      @(negedge clk);
      c++;
    end
    chk("drain_sb", sb.size(), 0);
    chk("drain_valid", line_valid, 0);
  endtask

  always @(negedge clk) begin
    if (frame_start === 1'b1) fs_count++;
  end

  initial begin
    forever begin
      @(negedge clk);
      if (auto_ack && line_valid === 1'b1) consume_line(1'b1);
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_valid", line_valid, 0);
    chk("rst_num", line_num, 0);
    chk("rst_len", line_len, 0);
    chk("rst_first", line_first, 0);
    chk("rst_trunc", line_trunc, 0);
    chk("rst_fs", frame_start, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_rd_data", rd_data, 0);
    rst = 1'b0;

    // single 8-pixel line, consumer reads it back
    auto_ack = 1'b1;
    send_vblank();
    send_line(8, 1'b1, 1'b0, 1'b1);
    wait_drain();

    // two frames of three lines with immediate acks
    for (int f = 0; f < 2; f++) begin
      send_vblank();
      for (int l = 0; l < 3; l++) begin
        send_line(6, 1'b1, 1'b0, 1'b0);
        repeat (12) @(posedge clk);
      end
    end
    wait_drain();
    chk("no_drops", drop_count, 0);

    // consumer stalls: two lines held, two dropped, then one-cycle gap
    auto_ack = 1'b0;
    send_vblank();
    send_line(5, 1'b1, 1'b0, 1'b0);
    send_line(5, 1'b1, 1'b0, 1'b0);
    send_line(5, 1'b0, 1'b0, 1'b0);
    send_line(5, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("held_valid", line_valid, 1);
    chk("held_num", line_num, 0);
    chk("drop_cnt2", drop_count, 2);
    consume_line(1'b1);
    @(negedge clk);
    chk("gap_valid", line_valid, 1);
    chk("gap_num", line_num, 1);
    auto_ack = 1'b1;
    wait_drain();

    // overlong line is truncated at the bank depth
    send_vblank();
    send_line(700, 1'b1, 1'b0, 1'b0);
    wait_drain();

    // vblank ends a line mid-way; next pixel opens a new frame
    send_line(5, 1'b1, 1'b1, 1'b0);
    send_line(3, 1'b1, 1'b0, 1'b0);
    wait_drain();
    chk("fs_count_mid", fs_count, fs_exp);

    // async reset with one bank full and a line in progress
    auto_ack = 1'b0;
    send_vblank();
    send_line(4, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) strobe(14'h1234, 1'b0, 1'b0);
    @(posedge clk); #5;
    rst = 1'b1;
    #1;
    chk("arst_valid", line_valid, 0);
    chk("arst_drop", drop_count, 0);
    chk("arst_len", line_len, 0);
    chk("arst_rd_data", rd_data, 0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    in_vblank = 1'b1;
    next_num = 0;
    auto_ack = 1'b1;
    send_line(4, 1'b1, 1'b0, 1'b1);
    wait_drain();

    chk("fs_count_end", fs_count, fs_exp);
    chk("sb_empty_end", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
